// File: rtl/adder_client.sv
// adder_client
//   Host-side front end for the adder. Addends arrive on a valid/ready request
//   port, are buffered in a FIFO, and are replayed to the adder as a single
//   AXI-Stream transaction. Once the beat carrying tlast has been handshaken
//   the block parks in DONE until reset.
//
// Ports
//   clk, rst                       sole clock; synchronous active-high reset
//   client_tdata/tlast/tvalid      host request (addend, last marker, valid)
//   client_tready                  block can take a request this cycle
//   axis_client_interface_t*       AXIS master toward the adder slave port
//                                  (tdata is the addend zero-extended)
//   done                           tlast beat has been handshaken
//   sent_count                     AXIS beats handshaken since reset (saturating)
//   state_dbg                      FSM state: 0=FILL, 1=DRAIN, 2=DONE
//
// Handshake semantics (both ports): a transfer happens on a rising clk edge
// where valid and ready are both high. Valid never depends on ready; once the
// AXIS valid is up, tdata/tlast stay stable until the transfer because the
// FIFO head only moves on a read.

module adder_client #(
  parameter int DATAW          = 128,
  parameter int AXIS_MAX_DATAW = 512,
  parameter int DEPTH          = 16,
  parameter int CNTW           = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [DATAW-1:0]          client_tdata,
  input  logic                      client_tlast,
  input  logic                      client_tvalid,
  output logic                      client_tready,
  output logic                      axis_client_interface_tvalid,
  output logic                      axis_client_interface_tlast,
  output logic [AXIS_MAX_DATAW-1:0] axis_client_interface_tdata,
  input  logic                      axis_client_interface_tready,
  output logic                      done,
  output logic [CNTW-1:0]           sent_count,
  output logic [1:0]                state_dbg
);

  localparam int            AW       = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t          state_q, state_d;

  // Each entry is {last, data}.
  logic [DATAW:0]  mem [DEPTH];
  logic [AW-1:0]   rd_ptr, wr_ptr;
  logic [AW:0]     occ;

  logic            wr_en, rd_en;
  logic            fifo_empty;
  logic [DATAW:0]  head;

  assign fifo_empty = (occ == '0);
  assign head       = mem[rd_ptr];

  // Ready looks only at registered occupancy, so a read in the same cycle
  // never opens a slot for a write while full.
  assign client_tready = (state_q == FILL) && (occ != FULL_CNT) && !rst;
  assign wr_en         = client_tvalid && client_tready;

  assign axis_client_interface_tvalid = !fifo_empty && (state_q != DONE);
  assign rd_en = axis_client_interface_tvalid && axis_client_interface_tready;

  always_comb begin
    axis_client_interface_tdata = '0;
    axis_client_interface_tlast = 1'b0;
    if (!fifo_empty) begin
      axis_client_interface_tdata[DATAW-1:0] = head[DATAW-1:0];
      axis_client_interface_tlast            = head[DATAW];
    end
  end

  assign done      = (state_q == DONE);
  assign state_dbg = state_q;

  // Storage array is not reset; occupancy gating hides stale contents.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= {client_tlast, client_tdata};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      occ    <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (rd_en) rd_ptr <= rd_ptr + AW'(1);
      case ({wr_en, rd_en})
        2'b10:   occ <= occ + (AW+1)'(1);
        2'b01:   occ <= occ - (AW+1)'(1);
        default: occ <= occ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sent_count <= '0;
    end else if (rd_en && (sent_count != {CNTW{1'b1}})) begin
      sent_count <= sent_count + CNTW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= FILL;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      FILL:    if (wr_en && client_tlast) state_d = DRAIN;
      DRAIN:   if (rd_en && head[DATAW])  state_d = DONE;
      DONE:    state_d = DONE;
      default: state_d = FILL;
    endcase
  end

endmodule

// File: tb/tb_adder_client.sv
module tb_adder_client;

  localparam int DATAW = 128;
  localparam int AXW   = 512;
  localparam int DEPTH = 16;
  localparam int CNTW  = 16;
  localparam int W     = DATAW + 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [DATAW-1:0] client_tdata = '0;
  logic             client_tlast = 1'b0;
  logic             client_tvalid = 1'b0;
  logic             client_tready;
  logic             axis_tvalid, axis_tlast, axis_tready;
  logic [AXW-1:0]   axis_tdata;
  logic             done;
  logic [CNTW-1:0]  sent_count;
  logic [1:0]       state_dbg;

  adder_client #(.DATAW(DATAW), .AXIS_MAX_DATAW(AXW), .DEPTH(DEPTH), .CNTW(CNTW)) dut (
    .clk                          (clk),
    .rst                          (rst),
    .client_tdata                 (client_tdata),
    .client_tlast                 (client_tlast),
    .client_tvalid                (client_tvalid),
    .client_tready                (client_tready),
    .axis_client_interface_tvalid (axis_tvalid),
    .axis_client_interface_tlast  (axis_tlast),
    .axis_client_interface_tdata  (axis_tdata),
    .axis_client_interface_tready (axis_tready),
    .done                         (done),
    .sent_count                   (sent_count),
    .state_dbg                    (state_dbg)
  );

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];    // {last, data} of accepted addends, in order
  int   errors = 0;
  int   checks = 0;
  bit   locked   = 0;        // a tlast addend has been accepted
  bit   finished = 0;        // the tlast beat has left on AXIS
  int   pops     = 0;        // AXIS beats expected to have been handshaken
  longint beat_sum = 0;
  int   tready_mode = 0;     // 0: hold low, 1: hold high, 2: random, 3: manual

  task automatic check(input string name, input logic [AXW-1:0] act, input logic [AXW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- adder-side tready stimulus ----------------
  initial begin
    axis_tready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (tready_mode)
        0:       axis_tready = 1'b0;
        1:       axis_tready = 1'b1;
        2:       axis_tready = ($urandom_range(0, 3) != 0);
        default: ;
      endcase
    end
  end

  // ---------------- monitor: compare every cycle, pop on AXIS handshake ----------------
  always @(negedge clk) begin
    logic             exp_ready, exp_valid;
    logic [W-1:0]     head;
    logic [AXW-1:0]   exp_data;
    int               exp_state;
    if (rst) begin
      check("tready_in_reset", AXW'(client_tready), AXW'(0));
      exp_q.delete();
      locked = 0; finished = 0; pops = 0;
    end else begin
      exp_ready = !locked && (exp_q.size() != DEPTH);
      exp_valid = (exp_q.size() != 0) && !finished;
      head      = exp_valid ? exp_q[0] : '0;
      exp_data  = '0;
      exp_data[DATAW-1:0] = head[DATAW-1:0];
      exp_state = finished ? 2 : (locked ? 1 : 0);
      check("client_tready", AXW'(client_tready), AXW'(exp_ready));
      check("axis_tvalid",   AXW'(axis_tvalid),   AXW'(exp_valid));
      check("axis_tdata",    axis_tdata,          exp_data);
      check("axis_tlast",    AXW'(axis_tlast),    AXW'(head[DATAW]));
      check("done",          AXW'(done),          AXW'(finished));
      check("sent_count",    AXW'(sent_count),    AXW'((pops > 65535) ? 65535 : pops));
      check("state",         AXW'(state_dbg),     AXW'(exp_state));
      if (exp_valid && axis_tready) begin
        void'(exp_q.pop_front());
        pops++;
        beat_sum += longint'(head[31:0]);
        if (head[DATAW]) finished = 1;
      end
      if (client_tvalid && exp_ready && client_tlast) locked = 1;
    end
  end

  // ---------------- driver tasks ----------------
  // Called at posedge+1; returns at the following posedge+1.
  task automatic push(input logic [DATAW-1:0] d, input logic l, input int budget, output bit ok);
    client_tdata  = d;
    client_tlast  = l;
    client_tvalid = 1'b1;
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (client_tready) begin
        ok = 1;
        break;
      end
      if (i != budget - 1) @(posedge clk);
    end
    @(posedge clk);
    if (ok) exp_q.push_back({l, d});
    #1;
    client_tvalid = 1'b0;
    client_tdata  = '0;
    client_tlast  = 1'b0;
  endtask

  task automatic push_ok(input logic [DATAW-1:0] d, input logic l);
    bit ok;
    push(d, l, 200, ok);
    check("push_accepted", AXW'(ok), AXW'(1));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    bit seen = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1;
        break;
      end
    end
    check("done_within_budget", AXW'(seen), AXW'(1));
    check("queue_drained", AXW'(exp_q.size()), AXW'(0));
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DATAW-1:0] rnd_data();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------- test sequence ----------------
  initial begin
    bit ok;
    logic [DATAW-1:0] ones;
    logic [AXW-1:0]   zext;

    // Reset values.
    do_reset();
    @(negedge clk);
    check("reset_tready", AXW'(client_tready), AXW'(1));
    check("reset_tvalid", AXW'(axis_tvalid), AXW'(0));
    check("reset_tdata",  axis_tdata, AXW'(0));
    check("reset_done",   AXW'(done), AXW'(0));
    check("reset_count",  AXW'(sent_count), AXW'(0));
    @(posedge clk); #1;

    // Basic: 5, 7, 30 with the adder always ready.
    tready_mode = 1;
    @(posedge clk); #1;
    beat_sum = 0;
    push_ok(DATAW'(5), 1'b0);
    push_ok(DATAW'(7), 1'b0);
    push_ok(DATAW'(30), 1'b1);
    wait_done(20);
    check("basic_count", AXW'(sent_count), AXW'(3));
    check("basic_sum", AXW'(beat_sum), AXW'(42));
    $display("adder sum = %0d", beat_sum);

    // Backpressure: three addends held behind tready=0 for ten cycles.
    tready_mode = 0;
    do_reset();
    @(posedge clk); #1;
    push_ok(rnd_data(), 1'b0);
    push_ok(rnd_data(), 1'b0);
    push_ok(rnd_data(), 1'b1);
    repeat (7) @(posedge clk);
    #1 tready_mode = 1;
    wait_done(30);
    check("bp_count", AXW'(sent_count), AXW'(3));

    // Full: 16 accepted behind tready=0, the remaining 4 after release.
    tready_mode = 0;
    do_reset();
    @(posedge clk); #1;
    for (int i = 0; i < DEPTH; i++) push_ok(DATAW'(100 + i), 1'b0);
    @(negedge clk);
    check("full_tready_low", AXW'(client_tready), AXW'(0));
    @(posedge clk); #1;
    fork
      begin
        for (int i = 0; i < 4; i++) push_ok(DATAW'(200 + i), (i == 3));
      end
      begin
        repeat (10) @(posedge clk);
        #1 tready_mode = 1;
      end
    join
    wait_done(60);
    check("full_count", AXW'(sent_count), AXW'(20));

    // Drain lockout: 3 must be refused after the tlast addend.
    tready_mode = 0;
    do_reset();
    @(posedge clk); #1;
    push_ok(DATAW'(1), 1'b0);
    push_ok(DATAW'(2), 1'b1);
    push(DATAW'(3), 1'b0, 6, ok);
    check("drain_refuses", AXW'(ok), AXW'(0));
    tready_mode = 1;
    wait_done(20);
    check("drain_count", AXW'(sent_count), AXW'(2));
    check("drain_done", AXW'(done), AXW'(1));

    // Zero-extend of an all-ones addend.
    tready_mode = 0;
    do_reset();
    @(posedge clk); #1;
    ones = '1;
    push_ok(ones, 1'b1);
    @(negedge clk);
    zext = '0;
    zext[DATAW-1:0] = ones;
    check("zext_tdata", axis_tdata, zext);
    @(posedge clk); #1;
    tready_mode = 1;
    wait_done(20);

    // Reset after 2 of 4 beats, then a fresh 1-beat transaction.
    tready_mode = 3;
    axis_tready = 1'b0;
    do_reset();
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) push_ok(rnd_data(), (i == 3));
    axis_tready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    axis_tready = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("mid_rst_tvalid", AXW'(axis_tvalid), AXW'(0));
    check("mid_rst_tdata",  axis_tdata, AXW'(0));
    check("mid_rst_count",  AXW'(sent_count), AXW'(0));
    check("mid_rst_tready", AXW'(client_tready), AXW'(1));
    @(posedge clk); #1;
    tready_mode = 1;
    push_ok(DATAW'(9), 1'b1);
    wait_done(20);
    check("mid_rst_new_count", AXW'(sent_count), AXW'(1));

    // Random transactions with random adder backpressure.
    for (int t = 0; t < 12; t++) begin
      int n;
      tready_mode = 0;
      do_reset();
      tready_mode = 2;
      n = $urandom_range(1, 24);
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(0, 3) == 0) begin
          @(posedge clk); #1;
        end
        push_ok(rnd_data(), (i == n - 1));
      end
      wait_done(300);
      check("rand_count", AXW'(sent_count), AXW'(n));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Watchdog: always reach the summary line.
  initial begin
    #2000000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
